// File: rtl/alu_station.sv
// rtl/alu_station.sv - single-entry ALU reservation station with execute stage and own write port
// Holds one issued op, snoops the write bus until all locks clear, then fires a one-cycle write.
module alu_station #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush_in,
  input  logic             en_in,
  input  logic [31:0]      pc_in,
  input  logic [3:0]       op_in,
  input  logic [TAG_W-1:0] tagx_in,
  input  logic [TAG_W-1:0] tagy_in,
  input  logic [TAG_W-1:0] tagw_in,
  input  logic [31:0]      datax_in,
  input  logic [31:0]      datay_in,
  input  logic [4:0]       addrx_in,
  input  logic [4:0]       addry_in,
  input  logic [4:0]       addrw_in,
  input  logic             en_mw0,
  input  logic             en_mw1,
  input  logic             en_mw2,
  input  logic [4:0]       reg_write_addr0,
  input  logic [4:0]       reg_write_addr1,
  input  logic [4:0]       reg_write_addr2,
  input  logic [31:0]      write_data0,
  input  logic [31:0]      write_data1,
  input  logic [31:0]      write_data2,
  output logic             busy_out,
  output logic [TAG_W-1:0] tagx_out,
  output logic [TAG_W-1:0] tagy_out,
  output logic [TAG_W-1:0] tagw_out,
  output logic             en_mw_out,
  output logic [4:0]       reg_write_addr_out,
  output logic [31:0]      write_data_out
);

  localparam logic [TAG_W-1:0] UNLOCKED = '0;

  logic             valid;
  logic [3:0]       op_q;
  logic [31:0]      pc_q, datax_q, datay_q;
  logic [TAG_W-1:0] tagx_q, tagy_q, tagw_q;
  logic [4:0]       addrx_q, addry_q, addrw_q;

  logic             hit_x, hit_y, hit_w;
  logic [31:0]      snp_x, snp_y;
  logic             fire, accept;
  logic [31:0]      result;

  // Write-bus snoop; lower-numbered ports win, register 0 never matches.
  always_comb begin
    hit_x = 1'b0;
    hit_y = 1'b0;
    hit_w = 1'b0;
    snp_x = datax_q;
    snp_y = datay_q;
    if (addrx_q != 5'd0) begin
      if (en_mw0 && reg_write_addr0 == addrx_q) begin
        hit_x = 1'b1; snp_x = write_data0;
      end else if (en_mw1 && reg_write_addr1 == addrx_q) begin
        hit_x = 1'b1; snp_x = write_data1;
      end else if (en_mw2 && reg_write_addr2 == addrx_q) begin
        hit_x = 1'b1; snp_x = write_data2;
      end
    end
    if (addry_q != 5'd0) begin
      if (en_mw0 && reg_write_addr0 == addry_q) begin
        hit_y = 1'b1; snp_y = write_data0;
      end else if (en_mw1 && reg_write_addr1 == addry_q) begin
        hit_y = 1'b1; snp_y = write_data1;
      end else if (en_mw2 && reg_write_addr2 == addry_q) begin
        hit_y = 1'b1; snp_y = write_data2;
      end
    end
    if (addrw_q != 5'd0) begin
      hit_w = (en_mw0 && reg_write_addr0 == addrw_q) ||
              (en_mw1 && reg_write_addr1 == addrw_q) ||
              (en_mw2 && reg_write_addr2 == addrw_q);
    end
  end

  always_comb begin
    case (op_q)
      4'd0:    result = datax_q + datay_q;
      4'd1:    result = datax_q - datay_q;
      4'd2:    result = datax_q << datay_q[4:0];
      4'd3:    result = {31'd0, $signed(datax_q) < $signed(datay_q)};
      4'd4:    result = {31'd0, datax_q < datay_q};
      4'd5:    result = datax_q ^ datay_q;
      4'd6:    result = datax_q >> datay_q[4:0];
      4'd7:    result = $unsigned($signed(datax_q) >>> datay_q[4:0]);
      4'd8:    result = datax_q | datay_q;
      4'd9:    result = datax_q & datay_q;
      4'd10:   result = pc_q + datay_q;
      4'd11:   result = pc_q + 32'd4;
      4'd12:   result = datay_q;
      default: result = 32'd0;
    endcase
  end

  assign fire   = valid && tagx_q == UNLOCKED && tagy_q == UNLOCKED && tagw_q == UNLOCKED;
  assign accept = en_in && (!valid || fire);

  assign busy_out = valid;
  assign tagx_out = valid ? tagx_q : UNLOCKED;
  assign tagy_out = valid ? tagy_q : UNLOCKED;
  assign tagw_out = valid ? tagw_q : UNLOCKED;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid              <= 1'b0;
      op_q               <= 4'd0;
      pc_q               <= 32'd0;
      datax_q            <= 32'd0;
      datay_q            <= 32'd0;
      tagx_q             <= UNLOCKED;
      tagy_q             <= UNLOCKED;
      tagw_q             <= UNLOCKED;
      addrx_q            <= 5'd0;
      addry_q            <= 5'd0;
      addrw_q            <= 5'd0;
      en_mw_out          <= 1'b0;
      reg_write_addr_out <= 5'd0;
      write_data_out     <= 32'd0;
    end else if (rdy) begin
      if (flush_in) begin
        valid     <= 1'b0;
        en_mw_out <= 1'b0;
        tagx_q    <= UNLOCKED;
        tagy_q    <= UNLOCKED;
        tagw_q    <= UNLOCKED;
      end else begin
        en_mw_out <= fire && (addrw_q != 5'd0);
        if (fire) begin
          reg_write_addr_out <= addrw_q;
          write_data_out     <= result;
        end
        if (accept) begin
          valid   <= 1'b1;
          op_q    <= op_in;
          pc_q    <= pc_in;
          datax_q <= datax_in;
          datay_q <= datay_in;
          tagx_q  <= tagx_in;
          tagy_q  <= tagy_in;
          tagw_q  <= tagw_in;
          addrx_q <= addrx_in;
          addry_q <= addry_in;
          addrw_q <= addrw_in;
        end else if (fire) begin
          valid <= 1'b0;
        end else if (valid) begin
          if (tagx_q != UNLOCKED && hit_x) begin
            tagx_q  <= UNLOCKED;
            datax_q <= snp_x;
          end
          if (tagy_q != UNLOCKED && hit_y) begin
            tagy_q  <= UNLOCKED;
            datay_q <= snp_y;
          end
          if (tagw_q != UNLOCKED && hit_w) tagw_q <= UNLOCKED;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_station.sv
// tb/tb_alu_station.sv - directed self-checking bench for alu_station
// Inputs change on negedge, outputs are sampled on negedge.
module tb_alu_station;

  logic        clk = 1'b0;
  logic        rst, rdy, flush_in, en_in;
  logic [31:0] pc_in;
  logic [3:0]  op_in;
  logic [3:0]  tagx_in, tagy_in, tagw_in;
  logic [31:0] datax_in, datay_in;
  logic [4:0]  addrx_in, addry_in, addrw_in;
  logic        en_mw0, en_mw1, en_mw2;
  logic [4:0]  reg_write_addr0, reg_write_addr1, reg_write_addr2;
  logic [31:0] write_data0, write_data1, write_data2;
  logic        busy_out;
  logic [3:0]  tagx_out, tagy_out, tagw_out;
  logic        en_mw_out;
  logic [4:0]  reg_write_addr_out;
  logic [31:0] write_data_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_station #(.TAG_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush_in(flush_in), .en_in(en_in),
    .pc_in(pc_in), .op_in(op_in),
    .tagx_in(tagx_in), .tagy_in(tagy_in), .tagw_in(tagw_in),
    .datax_in(datax_in), .datay_in(datay_in),
    .addrx_in(addrx_in), .addry_in(addry_in), .addrw_in(addrw_in),
    .en_mw0(en_mw0), .en_mw1(en_mw1), .en_mw2(en_mw2),
    .reg_write_addr0(reg_write_addr0), .reg_write_addr1(reg_write_addr1),
    .reg_write_addr2(reg_write_addr2),
    .write_data0(write_data0), .write_data1(write_data1), .write_data2(write_data2),
    .busy_out(busy_out), .tagx_out(tagx_out), .tagy_out(tagy_out), .tagw_out(tagw_out),
    .en_mw_out(en_mw_out), .reg_write_addr_out(reg_write_addr_out),
    .write_data_out(write_data_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] pc,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [3:0] tx, input logic [3:0] ty, input logic [3:0] tw,
                       input logic [4:0] ax, input logic [4:0] ay, input logic [4:0] aw);
    en_in = 1'b1; op_in = op; pc_in = pc; datax_in = x; datay_in = y;
    tagx_in = tx; tagy_in = ty; tagw_in = tw;
    addrx_in = ax; addry_in = ay; addrw_in = aw;
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Unlocked op: accepted at the next edge, fires at the one after.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] pc,
                        input logic [31:0] x, input logic [31:0] y, input logic [4:0] aw,
                        input logic [31:0] exp);
    issue(op, pc, x, y, 4'd0, 4'd0, 4'd0, 5'd1, 5'd2, aw);
    step();
    en_in = 1'b0;
    step();
    check({tag, "_data"}, write_data_out, exp);
    check({tag, "_en"}, {31'd0, en_mw_out}, {31'd0, aw != 5'd0});
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush_in = 1'b0; en_in = 1'b0;
    pc_in = 0; op_in = 0; tagx_in = 0; tagy_in = 0; tagw_in = 0;
    datax_in = 0; datay_in = 0; addrx_in = 0; addry_in = 0; addrw_in = 0;
    en_mw0 = 0; en_mw1 = 0; en_mw2 = 0;
    reg_write_addr0 = 0; reg_write_addr1 = 0; reg_write_addr2 = 0;
    write_data0 = 0; write_data1 = 0; write_data2 = 0;
    step(); step();
    check("rst_busy", {31'd0, busy_out}, 32'd0);
    check("rst_en", {31'd0, en_mw_out}, 32'd0);
    check("rst_addr", {27'd0, reg_write_addr_out}, 32'd0);
    check("rst_data", write_data_out, 32'd0);
    check("rst_tags", {20'd0, tagx_out, tagy_out, tagw_out}, 32'd0);
    rst = 1'b0;

    // ADD 5+7 -> r3
    issue(4'd0, 32'h0, 32'd5, 32'd7, 4'd0, 4'd0, 4'd0, 5'd1, 5'd2, 5'd3);
    step();
    en_in = 1'b0;
    check("add_busy_held", {31'd0, busy_out}, 32'd1);
    step();
    check("add_en", {31'd0, en_mw_out}, 32'd1);
    check("add_addr", {27'd0, reg_write_addr_out}, 32'd3);
    check("add_data", write_data_out, 32'd12);
    check("add_busy_after", {31'd0, busy_out}, 32'd0);
    step();
    check("add_en_drop", {31'd0, en_mw_out}, 32'd0);

    // SUB waiting on r4 (tag 2), released by port 1
    issue(4'd1, 32'h0, 32'd0, 32'd1, 4'd2, 4'd0, 4'd0, 5'd4, 5'd2, 5'd5);
    step();
    en_in = 1'b0;
    check("sub_tagx", {28'd0, tagx_out}, 32'd2);
    step(); step();
    check("sub_wait_en", {31'd0, en_mw_out}, 32'd0);
    check("sub_wait_busy", {31'd0, busy_out}, 32'd1);
    en_mw1 = 1'b1; reg_write_addr1 = 5'd4; write_data1 = 32'd100;
    step();
    en_mw1 = 1'b0;
    check("sub_tag_clear", {28'd0, tagx_out}, 32'd0);
    check("sub_no_early_fire", {31'd0, en_mw_out}, 32'd0);
    step();
    check("sub_en", {31'd0, en_mw_out}, 32'd1);
    check("sub_addr", {27'd0, reg_write_addr_out}, 32'd5);
    check("sub_data", write_data_out, 32'd99);

    // Port priority: port 0 beats port 2 on the same register
    issue(4'd0, 32'h0, 32'd0, 32'd0, 4'd3, 4'd0, 4'd0, 5'd6, 5'd2, 5'd7);
    step();
    en_in = 1'b0;
    en_mw0 = 1'b1; reg_write_addr0 = 5'd6; write_data0 = 32'd11;
    en_mw2 = 1'b1; reg_write_addr2 = 5'd6; write_data2 = 32'd22;
    step();
    en_mw0 = 1'b0; en_mw2 = 1'b0;
    step();
    check("prio_data", write_data_out, 32'd11);

    // Back-to-back: XOR fires while AND (dest locked) is accepted
    issue(4'd5, 32'h0, 32'hF0, 32'h0F, 4'd0, 4'd0, 4'd0, 5'd1, 5'd2, 5'd8);
    step();
    issue(4'd9, 32'h0, 32'hFF, 32'h0F, 4'd0, 4'd0, 4'd1, 5'd1, 5'd2, 5'd9);
    step();
    en_in = 1'b0;
    check("b2b_en", {31'd0, en_mw_out}, 32'd1);
    check("b2b_data", write_data_out, 32'hFF);
    check("b2b_addr", {27'd0, reg_write_addr_out}, 32'd8);
    check("b2b_busy", {31'd0, busy_out}, 32'd1);
    check("b2b_tagw", {28'd0, tagw_out}, 32'd1);

    // Flush the waiting AND
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    check("flush_busy", {31'd0, busy_out}, 32'd0);
    check("flush_en", {31'd0, en_mw_out}, 32'd0);
    check("flush_tagw", {28'd0, tagw_out}, 32'd0);
    step();
    check("flush_no_write", {31'd0, en_mw_out}, 32'd0);

    run_op("aw0", 4'd0, 32'h0, 32'd1, 32'd1, 5'd0, 32'd2);
    check("aw0_addr", {27'd0, reg_write_addr_out}, 32'd0);
    run_op("sra", 4'd7, 32'h0, 32'h80000000, 32'd4, 5'd10, 32'hF8000000);
    run_op("slt", 4'd3, 32'h0, 32'hFFFFFFFF, 32'd1, 5'd11, 32'd1);
    run_op("sltu", 4'd4, 32'h0, 32'hFFFFFFFF, 32'd1, 5'd11, 32'd0);
    run_op("sll", 4'd2, 32'h0, 32'h1, 32'd35, 5'd12, 32'h8);
    run_op("srl", 4'd6, 32'h0, 32'h80000000, 32'd4, 5'd12, 32'h08000000);
    run_op("auipc", 4'd10, 32'h1000, 32'd0, 32'h20, 5'd13, 32'h1020);
    run_op("link", 4'd11, 32'h1000, 32'd0, 32'd0, 5'd13, 32'h1004);
    run_op("lui", 4'd12, 32'h0, 32'd0, 32'hABCD0000, 5'd14, 32'hABCD0000);
    run_op("undef", 4'd15, 32'h0, 32'd3, 32'd4, 5'd14, 32'd0);

    // rdy low freezes the write port
    rdy = 1'b0;
    step();
    check("rdy_hold_en", {31'd0, en_mw_out}, 32'd1);
    issue(4'd0, 32'h0, 32'd1, 32'd2, 4'd0, 4'd0, 4'd0, 5'd1, 5'd2, 5'd3);
    step();
    check("rdy_no_accept", {31'd0, busy_out}, 32'd0);
    en_in = 1'b0;
    rdy = 1'b1;

    // Reset mid-operation
    issue(4'd0, 32'h0, 32'd1, 32'd2, 4'd5, 4'd0, 4'd0, 5'd9, 5'd2, 5'd3);
    step();
    en_in = 1'b0;
    check("mid_busy", {31'd0, busy_out}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy_out}, 32'd0);
    check("mid_rst_tagx", {28'd0, tagx_out}, 32'd0);
    step();
    rst = 1'b0;
    step();
    check("mid_rst_no_write", {31'd0, en_mw_out}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_station.md
# alu_station

Single-entry ALU reservation station plus execute stage: the receiving end of the dispatch allocator's ALU issue port. It latches one issued ALU operation with its operand tags, snoops the three register write ports until every pending operand and the destination lock are released, executes, and drives its own register write port for one cycle. Two instances sit in the core (alu0, alu1), each owning one write port on the write bus.

## Interface
- TAG_W, 4, register tag width; tag value 0 = UNLOCKED
- clk  in  1  clock; all state on posedge
- rst  in  1  reset; asynchronous, active-high
- rdy  in  1  global enable; 0 freezes all state, including write-port outputs
- flush_in  in  1  branch mispredict; discards held op, no write
- en_in  in  1  issue strobe from the allocator
- pc_in  in  32  pc of the issued op
- op_in  in  4  ALU sub-op
- tagx_in, tagy_in, tagw_in  in  TAG_W each  operand and destination locks
- datax_in, datay_in  in  32 each  operand values, valid when tag UNLOCKED
- addrx_in, addry_in, addrw_in  in  5 each  source/destination register numbers
- en_mw0/1/2  in  1 each  write-bus port valid
- reg_write_addr0/1/2  in  5 each  write-bus register number
- write_data0/1/2  in  32 each  write-bus data
- busy_out  out  1  entry holds an op
- tagx_out, tagy_out, tagw_out  out  TAG_W each  current registered locks of held op
- en_mw_out  out  1  own write-port valid
- reg_write_addr_out  out  5  destination register
- write_data_out  out  32  result

## Operation
- State: valid, op, pc, datax/datay, tags, addrs. busy_out = valid; tag outputs = registered tags (UNLOCKED when !valid).
- Snoop (every edge, valid): for x, y, w independently, if tag != UNLOCKED and some en_mwK with reg_write_addrK == addr, clear tag; x/y also capture write_dataK. Priority port 0 > 1 > 2. Matching against addr 0 is ignored.
- Fire: at an edge where valid and all three registered tags are UNLOCKED: compute result, register en_mw_out = (addrw != 0), reg_write_addr_out = addrw, write_data_out = result; clear valid unless a new op is accepted same edge.
- Accept: en_in latched when !valid, or when the held op fires at that edge (allocator's "busy but all unlocked" case). Incoming operands latched unmodified (allocator already forwards same-cycle writes). en_in while valid and not firing is a protocol violation: ignored, entry unchanged.
- Ops: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 AUIPC (pc+datay), 11 LINK (pc+4), 12 LUI (datay); others give 0. Shift amount = datay[4:0]. 32-bit wrap arithmetic; SLT/SLTU yield 0/1.
- flush_in: clears valid, forces en_mw_out 0 next cycle, tags UNLOCKED; overrides en_in and fire.

## Timing
- Reset: valid 0, all tags UNLOCKED, en_mw_out 0, reg_write_addr_out 0, write_data_out 0, busy_out 0.
- en_mw_out is high for exactly one cycle per fire, deasserted the following edge unless another fire occurs.
- Latency: op accepted with all tags UNLOCKED at edge N fires at edge N+1; result visible cycle N+1.
- Operand released by a write-bus port in cycle M: tag clears at edge M, fire at edge M+1.
- Back-to-back: firing and accepting at one edge sustains one op per cycle.
- rdy low: no accept, no snoop, no fire; outputs hold (en_mw_out held; reset clears it).
- rst mid-operation discards held op immediately, no write.

## Test plan
- Reset then en_in ADD, x=5, y=7, tags UNLOCKED, addrw=3 -> next edge en_mw_out=1, addr 3, data 12; busy_out 0 afterward.
- SUB with tagx=2, addrx=4; three cycles later en_mw1 writes r4=100, y=1 -> tag clears that edge, fire next edge with 99.
- Simultaneous en_mw0 and en_mw2 both on addrx, data 11/22 -> captured 11.
- Held op ready, new en_in same cycle -> old result written, new op latched, busy_out stays 1.
- Waiting op, flush_in=1 -> busy_out 0 next cycle, no write; addrw=0 op fires with en_mw_out 0; SRA 0x80000000 by 4 -> 0xF8000000.
